// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter feeding a UART transmitter, with burst-limited fairness.
// Optional cycle watchdog on the transmitter handshake, enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int MAX_BURST      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       baud_clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       timeout_err
);

  if (MAX_BURST < 1 || MAX_BURST > 15 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_t          state, state_nxt;
  logic [1:0]      req_valid;
  logic [1:0][7:0] req_data;
  logic [3:0]      burst;
  logic            own, sel, keep_own, accept, abort;

  assign req_valid = {req1_valid, req0_valid};
  assign req_data  = {req1_data, req0_data};
  assign own       = grant[1];

  // burst==0 only right after reset: the nominal owner has no burst yet, so req0 wins a tie
  assign keep_own = req_valid[own] && (burst != 4'd0) && (burst < MAX_B);
  assign sel      = (req_valid[~own] && !keep_own) ? ~own : own;
  assign accept   = rst_n && (state == IDLE) && req_valid[sel];

  assign req0_ready = accept && !sel;
  assign req1_ready = accept && sel;

  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    case (state)
      IDLE:      if (accept) state_nxt = START;
      START:     begin
                   tx_start  = 1'b1;
                   state_nxt = WAIT_BUSY;
                 end
      WAIT_BUSY: if (tx_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge baud_clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_data <= 8'h00;
      grant   <= 2'b10;
      burst   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        tx_data <= req_data[sel];
        grant   <= sel ? 2'b10 : 2'b01;
        if (sel != own)       burst <= 4'd1;
        else if (burst < MAX_B) burst <= burst + 4'd1;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wd_cnt;
  logic       waiting;

  assign waiting = (state == WAIT_BUSY) || (state == WAIT_DONE);
  // abort on the cycle the count would reach the limit; the error pulse lands with the return to IDLE
  assign abort   = waiting && (wd_cnt == WD_LAST);

  always_ff @(posedge baud_clk) begin
    if (!rst_n) begin
      wd_cnt      <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= abort;
      if (state == START) wd_cnt <= 8'd0;
      else if (waiting)   wd_cnt <= wd_cnt + 8'd1;
    end
  end
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single byte, burst fairness, lone requester,
// reset mid-frame, and the watchdog (present or absent depending on UART_ARB_TIMEOUT_EN).
module tb_uart_tx_arbiter;
  logic       baud_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready;
  logic       tx_start, tx_busy, timeout_err;
  logic [7:0] tx_data;
  logic [1:0] grant;

  logic model_en = 1'b1, model_busy = 1'b0, force_busy = 1'b0;
  int   busy_len = 1, busy_cnt = 0, cyc = 0;
  int   checks = 0, errors = 0;

  uart_tx_arbiter #(.MAX_BURST(4), .TIMEOUT_CYCLES(8)) dut (
    .baud_clk(baud_clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 baud_clk = ~baud_clk;
  always @(posedge baud_clk) cyc <= cyc + 1;
  assign tx_busy = model_en ? model_busy : force_busy;

  // transmitter: busy rises on tx_start and is seen high for busy_len cycles after START
  always @(negedge baud_clk) begin
    if (tx_start) begin
      model_busy = 1'b1;
      busy_cnt   = busy_len + 1;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
      if (busy_cnt == 0) model_busy = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(negedge baud_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
  endtask

  task automatic wait_accept(output int at, output logic [1:0] rdy);
    at  = -1;
    rdy = 2'b00;
    #1;
    for (int k = 0; k < 60; k++) begin
      if (req0_ready || req1_ready) begin
        at  = cyc;
        rdy = {req1_ready, req0_ready};
        break;
      end
      next_cyc();
    end
    chk("accept_seen", 32'(at >= 0), 32'd1);
  endtask

  initial begin
    int a, a2, c0;
    logic [1:0] r, exp_r;
    logic saw;

    // reset with both requesters valid: readys must stay low
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    next_cyc();
    next_cyc();
    chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    chk("rst_grant", 32'(grant), 32'b10);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    next_cyc();

    // valid glitch that never meets a clock edge: nothing captured
    req0_data  = 8'h99;
    req0_valid = 1'b1;
    #2;
    req0_valid = 1'b0;
    next_cyc();
    chk("glitch_tx_start", 32'(tx_start), 32'd0);
    chk("glitch_tx_data", 32'(tx_data), 32'h00);
    chk("glitch_grant", 32'(grant), 32'b10);

    // single byte, transmitter busy for 10 cycles
    busy_len   = 10;
    req0_data  = 8'hA5;
    req0_valid = 1'b1;
    wait_accept(a, r);
    chk("t1_ready", 32'(r), 32'b01);
    next_cyc();
    chk("t1_ready_drop", 32'({req1_ready, req0_ready}), 32'd0);
    chk("t1_tx_start", 32'(tx_start), 32'd1);
    chk("t1_tx_data", 32'(tx_data), 32'hA5);
    chk("t1_grant", 32'(grant), 32'b01);
    next_cyc();
    chk("t1_start_pulse", 32'(tx_start), 32'd0);
    wait_accept(a2, r);
    chk("t1_spacing", 32'(a2 - a), 32'd13);
    next_cyc();
    req0_valid = 1'b0;
    repeat (15) next_cyc();
    chk("t1_hold_data", 32'(tx_data), 32'hA5);

    // tie after reset: blocks of four, req0 first
    do_reset();
    busy_len   = 1;
    req0_data  = 8'h11;
    req1_data  = 8'h22;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_r = (((i / 4) % 2) == 0) ? 2'b01 : 2'b10;
      wait_accept(a2, r);
      chk("t2_owner", 32'(r), 32'(exp_r));
      if (i > 0) chk("t2_spacing", 32'(a2 - a), 32'd4);
      a = a2;
      next_cyc();
      chk("t2_tx_data", 32'(tx_data), exp_r[0] ? 32'h11 : 32'h22);
      chk("t2_grant", 32'(grant), 32'(exp_r));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (6) next_cyc();

    // lone requester streams past the burst limit, then req0 takes over
    do_reset();
    req1_data  = 8'h30;
    req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_accept(a2, r);
      chk("t3_owner", 32'(r), 32'b10);
      if (i > 0) chk("t3_spacing", 32'(a2 - a), 32'd4);
      a = a2;
      next_cyc();
      chk("t3_tx_data", 32'(tx_data), 32'(8'h30 + i));
      req1_data = 8'(8'h31 + i);
    end
    req0_data  = 8'h77;
    req0_valid = 1'b1;
    wait_accept(a2, r);
    chk("t3_preempt", 32'(r), 32'b01);
    chk("t3_preempt_spacing", 32'(a2 - a), 32'd4);
    next_cyc();
    chk("t3_preempt_data", 32'(tx_data), 32'h77);
    chk("t3_preempt_grant", 32'(grant), 32'b01);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) next_cyc();

    // reset while in WAIT_DONE
    busy_len   = 10;
    req0_data  = 8'h5A;
    req0_valid = 1'b1;
    wait_accept(a, r);
    chk("t4_owner", 32'(r), 32'b01);
    next_cyc();
    req0_valid = 1'b0;
    repeat (3) next_cyc();
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    chk("t4_grant", 32'(grant), 32'b10);
    chk("t4_tx_data", 32'(tx_data), 32'h00);
    chk("t4_tx_start", 32'(tx_start), 32'd0);
    saw = 1'b0;
    repeat (3) begin
      next_cyc();
      if (tx_start) saw = 1'b1;
    end
    chk("t4_no_resend", 32'(saw), 32'd0);
    // transmitter still reports busy here; IDLE must ignore it
    req1_data  = 8'h3C;
    req1_valid = 1'b1;
    c0 = cyc;
    wait_accept(a2, r);
    chk("t4_busy_ignored", 32'(a2 - c0), 32'd0);
    chk("t4_owner2", 32'(r), 32'b10);
    next_cyc();
    req1_valid = 1'b0;
    repeat (15) next_cyc();

    // transmitter never answers
    model_en   = 1'b0;
    force_busy = 1'b0;
    req0_data  = 8'hC3;
    req0_valid = 1'b1;
    wait_accept(a, r);
    chk("t5_owner", 32'(r), 32'b01);
    next_cyc();
    req0_valid = 1'b0;
    chk("t5_tx_start", 32'(tx_start), 32'd1);
`ifdef UART_ARB_TIMEOUT_EN
    repeat (8) next_cyc();
    chk("t5_no_early_timeout", 32'(timeout_err), 32'd0);
    next_cyc();
    chk("t5_timeout_pulse", 32'(timeout_err), 32'd1);
    req1_data  = 8'h4B;
    req1_valid = 1'b1;
    wait_accept(a2, r);
    chk("t5_after_timeout_owner", 32'(r), 32'b10);
    chk("t5_after_timeout_cycle", 32'(a2 - a), 32'd10);
    next_cyc();
    req1_valid = 1'b0;
    chk("t5_timeout_single", 32'(timeout_err), 32'd0);
    chk("t5_new_start", 32'(tx_start), 32'd1);
    chk("t5_new_data", 32'(tx_data), 32'h4B);
`else
    req1_valid = 1'b1;
    begin
      logic saw_to, saw_rdy, saw_st;
      saw_to  = 1'b0;
      saw_rdy = 1'b0;
      saw_st  = 1'b0;
      repeat (1000) begin
        next_cyc();
        if (timeout_err) saw_to = 1'b1;
        if (req0_ready || req1_ready) saw_rdy = 1'b1;
        if (tx_start) saw_st = 1'b1;
      end
      chk("t5_no_timeout", 32'(saw_to), 32'd0);
      chk("t5_stuck_no_ready", 32'(saw_rdy), 32'd0);
      chk("t5_stuck_no_start", 32'(saw_st), 32'd0);
    end
    req1_valid = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
